// File: rtl/frame_buffer.sv
// Ping-pong frame buffer: stores N complex samples per bank, reads them back in bit-reversed or natural order.
// Latency: N cycles from first accepted input to first output; sustains one sample per clock on both sides.
// Backpressure: in_ready drops only when both banks are full; out_* hold steady while out_ready is low.
module frame_buffer #(
    parameter int N      = 32,
    parameter int IW     = 29,
    parameter int SHIFT  = 4,
    parameter int BITREV = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IW-1:0]          in_re,
    input  logic [IW-1:0]          in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IW+SHIFT-1:0]    out_re,
    output logic [IW+SHIFT-1:0]    out_im,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last
);

    localparam int OW = IW + SHIFT;
    localparam int AW = $clog2(N);

    typedef struct packed {
        logic [OW-1:0] re;
        logic [OW-1:0] im;
    } cplx_t;

    // Bank select is the address MSB: entries 0..N-1 are bank 0, N..2N-1 are bank 1.
    cplx_t mem [0:2*N-1];

    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic [AW-1:0] rd_idx;
    logic          wb;
    logic          rb;
    logic [1:0]    full;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_wrap;
    logic          rd_wrap;
    cplx_t         rd_dat;

    assign in_ready  = !full[wb] && !rst;
    assign out_valid = full[rb] && !rst;
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign wr_wrap   = (wcnt == AW'(N - 1));
    assign rd_wrap   = (rcnt == AW'(N - 1));

    always_comb begin
        rd_idx = rcnt;
        if (BITREV != 0) begin
            for (int i = 0; i < AW; i++) begin
                rd_idx[i] = rcnt[AW-1-i];
            end
        end
    end

    // A bank is only written while not full and only read while full, so set and clear never hit the same bit.
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (wr_fire && wr_wrap) begin
            full_set[wb] = 1'b1;
        end
        if (rd_fire && rd_wrap) begin
            full_clr[rb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wb, wcnt}] <= cplx_t'{re: {in_re, {SHIFT{1'b0}}}, im: {in_im, {SHIFT{1'b0}}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
            rcnt <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            full <= 2'b00;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (wr_fire) begin
                wcnt <= wr_wrap ? '0 : wcnt + AW'(1);
                if (wr_wrap) begin
                    wb <= ~wb;
                end
            end
            if (rd_fire) begin
                rcnt <= rd_wrap ? '0 : rcnt + AW'(1);
                if (rd_wrap) begin
                    rb <= ~rb;
                end
            end
        end
    end

    assign rd_dat   = mem[{rb, rd_idx}];
    assign out_re   = out_valid ? rd_dat.re : '0;
    assign out_im   = out_valid ? rd_dat.im : '0;
    assign out_idx  = out_valid ? rd_idx : '0;
    assign out_last = out_valid && rd_wrap;

endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: bit-reversed instance (a) and natural-order instance (b) sharing clock and reset.
module tb_frame_buffer;

    typedef struct packed {
        logic [4:0]  idx;
        logic [32:0] re;
        logic [32:0] im;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
    logic [28:0] in_re_a, in_im_a;
    logic [32:0] out_re_a, out_im_a;
    logic [4:0]  out_idx_a;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
    logic [28:0] in_re_b, in_im_b;
    logic [32:0] out_re_b, out_im_b;
    logic [4:0]  out_idx_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [28:0] fa_re [32];
    logic [28:0] fa_im [32];
    logic [28:0] fb_re [32];
    logic [28:0] fb_im [32];
    int          fa_cnt, fb_cnt;
    int          acc_cyc_a;
    int          out_cnt_a, out_cnt_b, mark_a, first_cyc_a, last_cyc_a;

    frame_buffer #(.N(32), .IW(29), .SHIFT(4), .BITREV(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_re(in_re_a), .in_im(in_im_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_re(out_re_a), .out_im(out_im_a),
        .out_idx(out_idx_a), .out_last(out_last_a)
    );

    frame_buffer #(.N(32), .IW(29), .SHIFT(4), .BITREV(0)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_re(in_re_b), .in_im(in_im_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_re(out_re_b), .out_im(out_im_b),
        .out_idx(out_idx_b), .out_last(out_last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Sign-extend and multiply by 16: the scaled value as a 33-bit two's complement number.
    function automatic logic [32:0] scale(input logic [28:0] v);
        logic signed [32:0] s;
        s = 33'($signed(v));
        return 33'(s * 16);
    endfunction

    function automatic logic [4:0] brev5(input logic [4:0] k);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = k[4-i];
        return r;
    endfunction

    task automatic try_a(input logic [28:0] re, input logic [28:0] im, output logic ok);
        logic [4:0] j;
        in_valid_a = 1'b1;
        in_re_a    = re;
        in_im_a    = im;
        @(negedge clk);
        ok = in_ready_a;
        if (ok) begin
            acc_cyc_a      = cyc;
            fa_re[fa_cnt]  = re;
            fa_im[fa_cnt]  = im;
            fa_cnt++;
            if (fa_cnt == 32) begin
                for (int k = 0; k < 32; k++) begin
                    j = brev5(5'(k));
                    q_a.push_back('{idx: j, re: scale(fa_re[j]), im: scale(fa_im[j]), last: (k == 31)});
                end
                fa_cnt = 0;
            end
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic try_b(input logic [28:0] re, input logic [28:0] im, output logic ok);
        in_valid_b = 1'b1;
        in_re_b    = re;
        in_im_b    = im;
        @(negedge clk);
        ok = in_ready_b;
        if (ok) begin
            fb_re[fb_cnt] = re;
            fb_im[fb_cnt] = im;
            fb_cnt++;
            if (fb_cnt == 32) begin
                for (int k = 0; k < 32; k++) begin
                    q_b.push_back('{idx: 5'(k), re: scale(fb_re[k]), im: scale(fb_im[k]), last: (k == 31)});
                end
                fb_cnt = 0;
            end
        end
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic drain_a(input int budget);
        for (int t = 0; t < budget && q_a.size() > 0; t++) begin
            @(posedge clk); #1;
        end
        chk("drain_a", 128'(q_a.size()), 0);
    endtask

    // Output monitor for instance a: scoreboard pop, hold-during-stall, zero-when-idle.
    initial begin
        exp_t        e;
        logic        stall;
        logic [71:0] prev;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_vld_a", 128'(out_valid_a), 1);
                    chk("hold_dat_a", 128'({out_re_a, out_im_a, out_idx_a, out_last_a}), 128'(prev));
                end
                if (!out_valid_a) begin
                    chk("idle_zero_a", 128'({out_re_a, out_im_a, out_idx_a, out_last_a}), 0);
                end else if (out_ready_a) begin
                    if (q_a.size() == 0) begin
                        chk("unexpected_out_a", 128'(out_idx_a), 128'h1_0000);
                    end else begin
                        e = q_a.pop_front();
                        chk("idx_a", 128'(out_idx_a), 128'(e.idx));
                        chk("re_a", 128'(out_re_a), 128'(e.re));
                        chk("im_a", 128'(out_im_a), 128'(e.im));
                        chk("last_a", 128'(out_last_a), 128'(e.last));
                        if (out_cnt_a == mark_a) first_cyc_a = cyc;
                        last_cyc_a = cyc;
                        out_cnt_a++;
                    end
                end
                stall = out_valid_a && !out_ready_a;
                prev  = {out_re_a, out_im_a, out_idx_a, out_last_a};
            end
        end
    end

    initial begin
        exp_t        e;
        logic        stall;
        logic [71:0] prev;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_vld_b", 128'(out_valid_b), 1);
                    chk("hold_dat_b", 128'({out_re_b, out_im_b, out_idx_b, out_last_b}), 128'(prev));
                end
                if (!out_valid_b) begin
                    chk("idle_zero_b", 128'({out_re_b, out_im_b, out_idx_b, out_last_b}), 0);
                end else if (out_ready_b) begin
                    if (q_b.size() == 0) begin
                        chk("unexpected_out_b", 128'(out_idx_b), 128'h1_0000);
                    end else begin
                        e = q_b.pop_front();
                        chk("idx_b", 128'(out_idx_b), 128'(e.idx));
                        chk("re_b", 128'(out_re_b), 128'(e.re));
                        chk("im_b", 128'(out_im_b), 128'(e.im));
                        chk("last_b", 128'(out_last_b), 128'(e.last));
                        out_cnt_b++;
                    end
                end
                stall = out_valid_b && !out_ready_b;
                prev  = {out_re_b, out_im_b, out_idx_b, out_last_b};
            end
        end
    end

    initial begin
        logic ok;
        int   stalls, acc, first_rej, c_acc;
        n_cmp = 0; n_bad = 0;
        fa_cnt = 0; fb_cnt = 0;
        out_cnt_a = 0; out_cnt_b = 0; mark_a = 0; first_cyc_a = 0; last_cyc_a = 0; acc_cyc_a = 0;
        rst = 1'b1;
        in_valid_a = 1'b0; out_ready_a = 1'b0; in_re_a = '0; in_im_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; in_re_b = '0; in_im_b = '0;

        // Reset state and release
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready_a", 128'(in_ready_a), 0);
        chk("rst_out_valid_a", 128'(out_valid_a), 0);
        chk("rst_out_zero_a", 128'({out_re_a, out_im_a, out_idx_a, out_last_a}), 0);
        chk("rst_in_ready_b", 128'(in_ready_b), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready_a", 128'(in_ready_a), 1);
        chk("post_rst_in_ready_b", 128'(in_ready_b), 1);
        chk("post_rst_out_valid_a", 128'(out_valid_a), 0);
        @(posedge clk); #1;

        // Ramp frame, bit-reversed readout
        out_ready_a = 1'b1;
        stalls = 0;
        for (int k = 0; k < 32; k++) begin
            try_a(29'(k), 29'(-k), ok);
            if (!ok) stalls++;
        end
        chk("ramp_stalls", 128'(stalls), 0);
        drain_a(200);

        // Extreme values: all-ones real, max positive imaginary
        out_ready_a = 1'b0;
        for (int k = 0; k < 32; k++) try_a(29'h1FFF_FFFF, 29'h0FFF_FFFF, ok);
        @(negedge clk);
        chk("ext_valid", 128'(out_valid_a), 1);
        chk("ext_re", 128'(out_re_a), 128'h1_FFFF_FFF0);
        chk("ext_im", 128'(out_im_a), 128'h0_FFFF_FFF0);
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        drain_a(200);

        // Three back-to-back frames: no bubbles, N-cycle latency
        mark_a = out_cnt_a;
        stalls = 0;
        c_acc  = 0;
        for (int k = 0; k < 96; k++) begin
            try_a(29'(k * 1000 + 5), 29'(-(k * 3) - 1), ok);
            if (!ok) stalls++;
            if (k == 0) c_acc = acc_cyc_a;
        end
        drain_a(200);
        chk("b2b_in_stalls", 128'(stalls), 0);
        chk("b2b_out_count", 128'(out_cnt_a - mark_a), 96);
        chk("b2b_latency", 128'(first_cyc_a - c_acc), 32);
        chk("b2b_out_span", 128'(last_cyc_a - first_cyc_a), 95);

        // Both banks full: exactly 64 accepts, then drain releases the write side
        out_ready_a = 1'b0;
        acc = 0;
        first_rej = -1;
        for (int k = 0; k < 70; k++) begin
            try_a(29'(k + 100), 29'(k + 200), ok);
            if (ok) acc++;
            else if (first_rej < 0) first_rej = k;
        end
        chk("full_accepts", 128'(acc), 64);
        chk("full_first_reject", 128'(first_rej), 64);
        @(negedge clk);
        chk("full_in_ready", 128'(in_ready_a), 0);
        @(posedge clk); #1;
        mark_a = out_cnt_a;
        out_ready_a = 1'b1;
        for (int t = 0; t < 100 && out_cnt_a < mark_a + 32; t++) begin
            @(posedge clk); #1;
        end
        chk("full_frame1_out", 128'(out_cnt_a - mark_a), 32);
        @(negedge clk);
        chk("full_in_ready_back", 128'(in_ready_a), 1);
        @(posedge clk); #1;
        drain_a(200);

        // Reset with one complete unread frame plus a partial frame
        out_ready_a = 1'b0;
        for (int k = 0; k < 42; k++) try_a(29'(k + 300), 29'(k + 400), ok);
        rst = 1'b1;
        q_a.delete();
        fa_cnt = 0;
        @(negedge clk);
        chk("midrst_in_ready", 128'(in_ready_a), 0);
        chk("midrst_out_valid", 128'(out_valid_a), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_in_ready", 128'(in_ready_a), 1);
        chk("midrst_release_out_valid", 128'(out_valid_a), 0);
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        mark_a = out_cnt_a;
        for (int k = 0; k < 32; k++) try_a(29'(k + 500), 29'(-k - 500), ok);
        drain_a(200);
        chk("midrst_fresh_count", 128'(out_cnt_a - mark_a), 32);

        // Natural-order instance under random backpressure
        for (int k = 0; k < 64; k++) try_b(29'(k * 77 + 9), 29'(-(k * 5)), ok);
        for (int t = 0; t < 2000 && q_b.size() > 0; t++) begin
            out_ready_b = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready_b = 1'b0;
        chk("nat_drain", 128'(q_b.size()), 0);
        chk("nat_count", 128'(out_cnt_b), 64);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 SHALL have parameter N, default 32, meaning points per frame; power of two, at least 4.
REQ-002 SHALL have parameter IW, default 29, meaning input sample width per component, two's complement.
REQ-003 SHALL have parameter SHIFT, default 4, meaning left-shift (guard bits) applied on store; output width OW = IW+SHIFT.
REQ-004 SHALL have parameter BITREV, default 1, meaning 1 = read out in bit-reversed index order, 0 = natural order.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: input sample present.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-009 SHALL have port in_re, input, IW bits: real part.
REQ-010 SHALL have port in_im, input, IW bits: imaginary part.
REQ-011 SHALL have port out_valid, output, 1 bit: output sample present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the sample.
REQ-013 SHALL have port out_re, output, OW bits: real part, scaled.
REQ-014 SHALL have port out_im, output, OW bits: imaginary part, scaled.
REQ-015 SHALL have port out_idx, output, log2(N) bits: storage index of the current output sample.
REQ-016 SHALL have port out_last, output, 1 bit: current output is the final sample of a frame.

Function
REQ-017 SHALL store samples in two banks (ping-pong) of N complex entries each, with a registered full flag per bank.
REQ-018 SHALL accept a write when in_valid and in_ready are both 1, storing at write bank wb, index wcnt, then incrementing wcnt.
REQ-019 SHALL store each component as {in, SHIFT zero bits}: an arithmetic left shift, sign preserved, no saturation needed.
REQ-020 SHALL, on the accept with wcnt = N-1, set full[wb], toggle wb and wrap wcnt to 0 in the same cycle.
REQ-021 SHALL drive in_ready = !full[wb] && !rst; write side stalls only when both banks are full.
REQ-022 SHALL drive out_valid = full[rb]; it rises the cycle after the final write of a frame.
REQ-023 SHALL drive out_idx = bit-reverse of rcnt when BITREV=1, else rcnt; out_re and out_im = bank rb at index out_idx.
REQ-024 SHALL drive out_last = out_valid && rcnt = N-1, and drive out_re, out_im and out_idx to 0 whenever out_valid = 0.
REQ-025 SHALL transfer a sample when out_valid and out_ready are both 1, incrementing rcnt; on the transfer with rcnt = N-1, clear full[rb], toggle rb and wrap rcnt to 0.
REQ-026 SHALL hold out_* stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL update write side and read side independently in the same cycle; they never address the same bank at once.
REQ-028 SHALL sustain 1 sample/clock in and out with no bubbles when out_ready = 1 continuously; latency from first input accept to first output is N cycles.
REQ-029 SHALL ignore in_valid while in_ready = 0; the sample is neither stored nor counted.

Reset
REQ-030 SHALL, with rst = 1 at a clock edge, set wcnt = rcnt = 0, wb = rb = 0 and full[0] = full[1] = 0; storage contents need not be cleared.
REQ-031 SHALL hold in_ready = 0 and out_valid = 0 (so out_re, out_im, out_idx, out_last = 0) while rst = 1, and set in_ready = 1 on the first cycle after rst falls.
REQ-032 SHALL discard partial and complete unread frames on a reset asserted mid-operation; no stale sample ever appears at the output afterwards.

Verification
REQ-033 SHALL cover: N=32, BITREV=1, write in_re = k, in_im = -k for k = 0..31 -> outputs out_idx 0, 16, 8, 24, ...; out_re 0, 256, 128, 384, ...; out_last only on the 32nd output (idx 31).
REQ-034 SHALL cover: in_re = all-ones (-1), in_im = 2^28-1 -> out_re = -16, out_im = (2^28-1)*16 as OW=33-bit values.
REQ-035 SHALL cover: out_ready = 0, stream inputs continuously -> in_ready falls after exactly 64 accepts; the 65th sample is not stored; raise out_ready -> frame 1 drains intact, then in_ready returns to 1.
REQ-036 SHALL cover: three back-to-back frames with in_valid = out_ready = 1 -> zero idle cycles on both sides and correct per-frame ordering.
REQ-037 SHALL cover: reset after 10 accepts -> out_valid stays 0 until 32 fresh samples are written; the output holds only the fresh data.
REQ-038 SHALL cover: BITREV=0 with random out_ready -> outputs in natural order 0..31, each exactly once, values stable during stalls.
